// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - two-CPU snooping coherence bus controller with RAM arbitration
module coherence_bus_ctrl #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore
);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMRD, UPG, IFETCH} state_t;

  localparam logic [1:0] ACCESS = 2'd2;

  state_t          state, nstate;
  logic            g;      // granted requester, held for the whole transaction
  logic            o;      // the other CPU, i.e. the snooper
  logic            rr;     // round-robin pointer shared by all classes
  logic            pick;
  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] creq;

  assign o = ~g;

  // A data-side request is a read miss or an upgrade (modify intent on a line already held).
  assign dreq = dREN | (cctrans & ccwrite);

  // Select the highest non-empty request class, then pick a CPU from it round-robin.
  always_comb begin
    creq = '0;
    if (|dWEN)      creq = dWEN;
    else if (|dreq) creq = dreq;
    else            creq = iREN;
    pick = creq[rr] ? rr : ~rr;
  end

  // State register; grant and round-robin pointer only move when leaving IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      g     <= 1'b0;
      rr    <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IDLE && nstate != IDLE) begin
        g  <= pick;
        rr <= ~pick;
      end
    end
  end

  // Next-state and all outputs, decoded from state and the held grant.
  always_comb begin
    nstate      = state;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        if (|dWEN)      nstate = WB;
        else if (|dreq) nstate = SNOOP;
        else if (|iREN) nstate = IFETCH;
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = dstore[g];
        if (ramstate == ACCESS) begin
          dwait[g] = 1'b0;
          nstate   = IDLE;
        end
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[g];
        ccinv[o]       = ccwrite[g];
        if (cctrans[o]) begin
          if (dWEN[o])      nstate = C2C;
          else if (dREN[g]) nstate = RAMRD;
          else              nstate = UPG;
        end
      end
      C2C: begin
        // Dirty line is written back and forwarded to the requester in one RAM write.
        ccwait[o] = 1'b1;
        ramWEN    = 1'b1;
        ramaddr   = daddr[o];
        ramstore  = dstore[o];
        dload[g]  = dstore[o];
        if (ramstate == ACCESS) begin
          dwait[g] = 1'b0;
          dwait[o] = 1'b0;
          nstate   = IDLE;
        end
      end
      RAMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[g];
        if (ramstate == ACCESS) begin
          dload[g] = ramload;
          dwait[g] = 1'b0;
          nstate   = IDLE;
        end
      end
      UPG: begin
        dwait[g] = 1'b0;
        nstate   = IDLE;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[g];
        if (ramstate == ACCESS) begin
          iload[g] = ramload;
          iwait[g] = 1'b0;
          nstate   = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - directed self-checking bench for coherence_bus_ctrl
module tb_coherence_bus_ctrl;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic             CLK, RST;
  logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore;

  int n_chk  = 0;
  int n_fail = 0;

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .ramload(ramload), .ramstate(ramstate),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic test_reset();
    clear_inputs();
    iREN = 2'b11;
    RST = 1'b1;
    #12;
    n_chk++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL reset_iwait got %b exp 11", iwait); end
    n_chk++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL reset_dwait got %b exp 11", dwait); end
    n_chk++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ram got ren=%b wen=%b exp 0 0", ramREN, ramWEN); end
    n_chk++; if (ccwait !== 2'b00 || ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_cc got ccwait=%b ramaddr=%h exp 00 0", ccwait, ramaddr); end
    iREN = '0;
    step();
    RST = 1'b0;
  endtask

  // Both CPUs fetch continuously; grants must alternate starting at CPU0.
  task automatic test_ifetch_rr();
    int cnt0, cnt1;
    logic e;
    logic [1:0] ew;
    cnt0 = 0; cnt1 = 0;
    iaddr[0] = 32'h100; iaddr[1] = 32'h200;
    for (int r = 0; r < 10; r++) begin
      e = r[0];
      ew = 2'b11; ew[e] = 1'b0;
      iREN = 2'b11; ramstate = BUSY;
      step();
      #1;
      n_chk++; if (ramaddr !== (e ? 32'h200 : 32'h100) || ramREN !== 1'b1 || iwait !== 2'b11)
        begin n_fail++; $display("FAIL ifetch_busy r=%0d got addr=%h ren=%b iwait=%b exp addr for cpu%0d", r, ramaddr, ramREN, iwait, e); end
      ramstate = ACCESS; ramload = 32'hA000_0000 + 32'(r);
      #1;
      n_chk++; if (iwait !== ew || iload[e] !== 32'hA000_0000 + 32'(r) || iload[~e] !== 32'h0)
        begin n_fail++; $display("FAIL ifetch_done r=%0d got iwait=%b iload0=%h iload1=%h exp iwait=%b", r, iwait, iload[0], iload[1], ew); end
      if (iwait == 2'b10) cnt0++;
      if (iwait == 2'b01) cnt1++;
      step();
    end
    n_chk++; if (cnt0 != 5 || cnt1 != 5) begin n_fail++; $display("FAIL ifetch_fair got cnt0=%0d cnt1=%0d exp 5 5", cnt0, cnt1); end
    clear_inputs();
  endtask

  // CPU0 read miss, CPU1 acks clean: snoop then RAM read (ERROR must hold).
  task automatic test_snoop_ramrd();
    dREN[0] = 1'b1; daddr[0] = 32'h40; ramstate = ERROR;
    step();
    #1;
    n_chk++; if (ccwait !== 2'b10 || ccinv !== 2'b00 || ccsnoopaddr[1] !== 32'h40)
      begin n_fail++; $display("FAIL snoop_req got ccwait=%b ccinv=%b snoopaddr1=%h exp 10 00 40", ccwait, ccinv, ccsnoopaddr[1]); end
    step();
    n_chk++; if (ccwait !== 2'b10 || dwait !== 2'b11) begin n_fail++; $display("FAIL snoop_hold got ccwait=%b dwait=%b exp 10 11", ccwait, dwait); end
    cctrans[1] = 1'b1;
    step();
    cctrans = '0;
    #1;
    n_chk++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || dwait !== 2'b11)
      begin n_fail++; $display("FAIL ramrd_err got ren=%b wen=%b addr=%h dwait=%b exp 1 0 40 11", ramREN, ramWEN, ramaddr, dwait); end
    ramstate = ACCESS; ramload = 32'h1234_5678;
    #1;
    n_chk++; if (dload[0] !== 32'h1234_5678 || dwait !== 2'b10)
      begin n_fail++; $display("FAIL ramrd_done got dload0=%h dwait=%b exp 12345678 10", dload[0], dwait); end
    step();
    clear_inputs();
    #1;
    n_chk++; if (dwait !== 2'b11 || ramREN !== 1'b0) begin n_fail++; $display("FAIL ramrd_idle got dwait=%b ren=%b exp 11 0", dwait, ramREN); end
  endtask

  // CPU1 read-exclusive hits a dirty line in CPU0: cache-to-cache transfer.
  task automatic test_c2c();
    dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h80;
    step();
    #1;
    n_chk++; if (ccinv !== 2'b01 || ccwait !== 2'b01 || ccsnoopaddr[0] !== 32'h80)
      begin n_fail++; $display("FAIL c2c_snoop got ccinv=%b ccwait=%b snoopaddr0=%h exp 01 01 80", ccinv, ccwait, ccsnoopaddr[0]); end
    cctrans[0] = 1'b1; dWEN[0] = 1'b1; dstore[0] = 32'hDEAD_BEEF; daddr[0] = 32'h80; ramstate = BUSY;
    step();
    #1;
    n_chk++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL c2c_ram got wen=%b ren=%b addr=%h store=%h exp 1 0 80 deadbeef", ramWEN, ramREN, ramaddr, ramstore); end
    n_chk++; if (dload[1] !== 32'hDEAD_BEEF || dwait !== 2'b11 || ccwait !== 2'b01)
      begin n_fail++; $display("FAIL c2c_busy got dload1=%h dwait=%b ccwait=%b exp deadbeef 11 01", dload[1], dwait, ccwait); end
    ramstate = ACCESS;
    #1;
    n_chk++; if (dwait !== 2'b00) begin n_fail++; $display("FAIL c2c_done got dwait=%b exp 00", dwait); end
    step();
    clear_inputs();
  endtask

  // Write-back outranks an instruction fetch raised in the same cycle.
  task automatic test_wb_ifetch_priority();
    dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'hCAFE_F00D;
    iREN[1] = 1'b1; iaddr[1] = 32'h500; ramstate = ACCESS;
    step();
    #1;
    n_chk++; if (ramWEN !== 1'b1 || ramaddr !== 32'h300 || ramstore !== 32'hCAFE_F00D || dwait !== 2'b10 || iwait !== 2'b11)
      begin n_fail++; $display("FAIL prio_wb got wen=%b addr=%h store=%h dwait=%b iwait=%b exp 1 300 cafef00d 10 11", ramWEN, ramaddr, ramstore, dwait, iwait); end
    step();
    dWEN = '0;
    ramload = 32'h55;
    step();
    #1;
    n_chk++; if (ramREN !== 1'b1 || ramaddr !== 32'h500 || iwait !== 2'b01 || iload[1] !== 32'h55)
      begin n_fail++; $display("FAIL prio_if got ren=%b addr=%h iwait=%b iload1=%h exp 1 500 01 55", ramREN, ramaddr, iwait, iload[1]); end
    step();
    clear_inputs();
  endtask

  // CPU0 upgrade: invalidate CPU1, complete without touching RAM.
  task automatic test_upgrade();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'hC0;
    step();
    #1;
    n_chk++; if (ccinv !== 2'b10 || ccwait !== 2'b10 || ramREN !== 1'b0 || ramWEN !== 1'b0)
      begin n_fail++; $display("FAIL upg_snoop got ccinv=%b ccwait=%b ren=%b wen=%b exp 10 10 0 0", ccinv, ccwait, ramREN, ramWEN); end
    cctrans = 2'b11;
    step();
    cctrans = '0; ccwrite = '0;
    #1;
    n_chk++; if (dwait !== 2'b10 || ramREN !== 1'b0 || ramWEN !== 1'b0)
      begin n_fail++; $display("FAIL upg_done got dwait=%b ren=%b wen=%b exp 10 0 0", dwait, ramREN, ramWEN); end
    step();
    #1;
    n_chk++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL upg_once got dwait=%b exp 11", dwait); end
    clear_inputs();
  endtask

  // Reset in the middle of a stalled RAM read, then first grant goes to CPU0.
  task automatic test_reset_mid();
    dREN[0] = 1'b1; daddr[0] = 32'h44; ramstate = BUSY;
    step();
    cctrans[1] = 1'b1;
    step();
    cctrans = '0;
    #1;
    n_chk++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rst_pre got ren=%b exp 1", ramREN); end
    RST = 1'b1;
    #1;
    n_chk++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 2'b11 || ccwait !== 2'b00)
      begin n_fail++; $display("FAIL rst_mid got ren=%b addr=%h dwait=%b ccwait=%b exp 0 0 11 00", ramREN, ramaddr, dwait, ccwait); end
    step();
    RST = 1'b0;
    clear_inputs();
    iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; ramstate = ACCESS;
    step();
    #1;
    n_chk++; if (iwait !== 2'b10 || ramaddr !== 32'h100) begin n_fail++; $display("FAIL rst_first got iwait=%b addr=%h exp 10 100", iwait, ramaddr); end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ifetch_rr();
    test_snoop_ramrd();
    test_c2c();
    test_wb_ifetch_priority();
    test_upgrade();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
